// File: rtl/kf8253_seq_pkg.sv
// Shared types for the KF8253 bus sequencer: command opcodes, FSM states, access steps and the request record.
package kf8253_seq_pkg;

  typedef enum logic [1:0] {
    OP_PROGRAM    = 2'b00,
    OP_LATCH_READ = 2'b01
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_READ,
    ST_RECOVER,
    ST_RESP
  } state_e;

  typedef enum logic [2:0] {
    W_CTRL,
    W_LSB,
    W_MSB,
    R_LSB,
    R_MSB
  } step_e;

  typedef struct packed {
    op_e         op;
    logic [1:0]  counter;
    logic [1:0]  rw;
    logic [2:0]  mode;
    logic        bcd;
    logic [15:0] count;
  } req_t;

  localparam logic [1:0]  ADDR_CONTROL = 2'd3;
  localparam int unsigned CNT_W        = 8;

  // Step 0 is always the control word; rw selects which byte accesses follow.
  function automatic step_e step_of(input req_t r, input logic [1:0] idx);
    logic rd;
    rd = (r.op == OP_LATCH_READ);
    if (idx == 2'd0) return W_CTRL;
    if (idx == 2'd1 && r.rw != 2'b10) return rd ? R_LSB : W_LSB;
    return rd ? R_MSB : W_MSB;
  endfunction

  function automatic logic last_step(input req_t r, input logic [1:0] idx);
    return (idx == 2'd2) || (idx == 2'd1 && r.rw != 2'b11);
  endfunction

  function automatic logic [7:0] ctrl_word(input req_t r);
    if (r.op == OP_PROGRAM) return {r.counter, r.rw, r.mode, r.bcd};
    return {r.counter, 6'b000000};
  endfunction

endpackage

// File: rtl/kf8253_seq_fifo.sv
// Small request FIFO placed ahead of the sequencer FSM when KF8253_SEQ_FIFO_EN is defined.
module kf8253_seq_fifo
  import kf8253_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic push_i,
  input  req_t data_i,
  input  logic pop_i,
  output req_t data_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_t          mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop)  rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/kf8253_bus_sequencer.sv
// Expands PROGRAM / LATCH_READ commands into KF8253 cs_n/wr_n/rd_n access sequences; optional KF8253_SEQ_FIFO_EN request FIFO.
// States: IDLE accept | SETUP cs low, addr/data out | STROBE wr low | HOLD post-write | READ rd low | RECOVER cs high | RESP respond
module kf8253_bus_sequencer
  import kf8253_seq_pkg::*;
#(
  parameter int WR_PULSE = 2,
  parameter int RD_PULSE = 2,
  parameter int HOLD     = 2,
  parameter int RECOVERY = 1
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [1:0]  req_counter_i,
  input  logic [1:0]  req_rw_i,
  input  logic [2:0]  req_mode_i,
  input  logic        req_bcd_i,
  input  logic [15:0] req_count_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [15:0] rsp_data_o,
  output logic        rsp_error_o,
  output logic        busy_o,
  output logic        pit_cs_n_o,
  output logic        pit_rd_n_o,
  output logic        pit_wr_n_o,
  output logic [1:0]  pit_address_o,
  output logic [7:0]  pit_data_out_o,
  input  logic [7:0]  pit_data_in_i
);
  req_t             req_in, cmd, req_q, req_d;
  logic             cmd_valid, accept, idle_free, finish;
  state_e           state_q, state_d;
  step_e            cur;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       step_q, step_d;
  logic [7:0]       lsb_q, lsb_d, msb_q, msb_d;
  logic             cs_n_q, cs_n_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d, busy_q, busy_d;
  logic [1:0]       addr_q, addr_d;
  logic [7:0]       dout_q, dout_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
  logic [15:0]      rsp_data_q, rsp_data_d;

  assign req_in    = {req_op_i, req_counter_i, req_rw_i, req_mode_i, req_bcd_i, req_count_i};
  assign idle_free = (state_q == ST_IDLE) && !rsp_valid_q;
  assign accept    = cmd_valid && idle_free;

`ifdef KF8253_SEQ_FIFO_EN
  logic fifo_full, fifo_empty;

  kf8253_seq_fifo #(.DEPTH(4)) u_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .push_i  (req_valid_i),
    .data_i  (req_in),
    .pop_i   (accept),
    .data_o  (cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign cmd_valid   = !fifo_empty;
  assign req_ready_o = !fifo_full;
`else
  assign cmd         = req_in;
  assign cmd_valid   = req_valid_i;
  assign req_ready_o = idle_free && !reset_i;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    step_d      = step_q;
    req_d       = req_q;
    lsb_d       = lsb_q;
    msb_d       = msb_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    finish      = 1'b0;
    cur         = step_of(req_q, step_q);

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if ((cmd.op != OP_PROGRAM && cmd.op != OP_LATCH_READ) ||
              cmd.counter == 2'd3 || cmd.rw == 2'b00) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_data_d  = '0;
          end else begin
            req_d   = cmd;
            step_d  = 2'd0;
            lsb_d   = '0;
            msb_d   = '0;
            addr_d  = ADDR_CONTROL;
            dout_d  = ctrl_word(cmd);
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        if (cur == R_LSB || cur == R_MSB) begin
          state_d = ST_READ;
          cnt_d   = CNT_W'(RD_PULSE - 1);
        end else begin
          state_d = ST_STROBE;
          cnt_d   = CNT_W'(WR_PULSE - 1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(HOLD - 1);
        end
      end
      ST_HOLD: finish = (cnt_q == '0);
      ST_READ: begin
        if (cnt_q == '0) begin
          if (cur == R_LSB) lsb_d = pit_data_in_i;
          else              msb_d = pit_data_in_i;
          finish = 1'b1;
        end
      end
      ST_RECOVER: begin
        if (cnt_q == '0) begin
          state_d = ST_SETUP;
          addr_d  = req_q.counter;
          case (cur)
            W_LSB:   dout_d = req_q.count[7:0];
            W_MSB:   dout_d = req_q.count[15:8];
            default: dout_d = ctrl_word(req_q);
          endcase
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_error_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      if (last_step(req_q, step_q)) begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_error_d = 1'b0;
        rsp_data_d  = (req_q.op == OP_LATCH_READ) ? {msb_d, lsb_d} : 16'h0000;
      end else begin
        state_d = ST_RECOVER;
        cnt_d   = CNT_W'(RECOVERY - 1);
        step_d  = step_q + 2'd1;
      end
    end

    // Strobes are decoded from the next state so every PIT pin comes straight off a flop.
    cs_n_d = !(state_d inside {ST_SETUP, ST_STROBE, ST_HOLD, ST_READ});
    wr_n_d = (state_d != ST_STROBE);
    rd_n_d = (state_d != ST_READ);
    busy_d = state_d inside {ST_SETUP, ST_STROBE, ST_HOLD, ST_READ, ST_RECOVER};
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      step_q      <= '0;
      req_q       <= '0;
      lsb_q       <= '0;
      msb_q       <= '0;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      dout_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      req_q       <= req_d;
      lsb_q       <= lsb_d;
      msb_q       <= msb_d;
      cs_n_q      <= cs_n_d;
      wr_n_q      <= wr_n_d;
      rd_n_q      <= rd_n_d;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign pit_cs_n_o     = cs_n_q;
  assign pit_wr_n_o     = wr_n_q;
  assign pit_rd_n_o     = rd_n_q;
  assign pit_address_o  = addr_q;
  assign pit_data_out_o = dout_q;
  assign busy_o         = busy_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_error_o    = rsp_error_q;
  assign rsp_data_o     = rsp_data_q;

endmodule

// File: tb/tb_kf8253_bus_sequencer.sv
// Directed bench for kf8253_bus_sequencer: vector table of commands plus reset, backpressure and FIFO sequences.
module tb_kf8253_bus_sequencer;
  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [1:0]  req_op, req_counter, req_rw;
  logic [2:0]  req_mode;
  logic        req_bcd;
  logic [15:0] req_count;
  logic        rsp_valid, rsp_ready, rsp_error, busy;
  logic [15:0] rsp_data;
  logic        pit_cs_n, pit_rd_n, pit_wr_n;
  logic [1:0]  pit_address;
  logic [7:0]  pit_data_out, pit_data_in;

  always #5 clock = ~clock;

  kf8253_bus_sequencer dut (
    .clock_i        (clock),
    .reset_i        (reset),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_op_i       (req_op),
    .req_counter_i  (req_counter),
    .req_rw_i       (req_rw),
    .req_mode_i     (req_mode),
    .req_bcd_i      (req_bcd),
    .req_count_i    (req_count),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_data_o     (rsp_data),
    .rsp_error_o    (rsp_error),
    .busy_o         (busy),
    .pit_cs_n_o     (pit_cs_n),
    .pit_rd_n_o     (pit_rd_n),
    .pit_wr_n_o     (pit_wr_n),
    .pit_address_o  (pit_address),
    .pit_data_out_o (pit_data_out),
    .pit_data_in_i  (pit_data_in)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // PIT bus model: logs writes, serves read data, watches protocol rules.
  logic [9:0] wlog[$];
  logic [7:0] rdv [2];
  int         rd_idx, nrd, cs_low, strobe_viol, hold_viol;
  logic [1:0] rd_addr;
  logic       cs_prev = 1'b1, wr_prev = 1'b1, rd_prev = 1'b1;
  logic [1:0] a_prev = '0;
  logic [7:0] d_prev = '0;

  always @(negedge clock) begin
    if (!reset) begin
      if (!pit_wr_n && !pit_rd_n) strobe_viol++;
      if (!pit_cs_n && !cs_prev && (pit_address != a_prev || pit_data_out != d_prev)) hold_viol++;
      if (!pit_cs_n) cs_low++;
      if (!pit_wr_n && wr_prev) wlog.push_back({pit_address, pit_data_out});
      if (!pit_rd_n && rd_prev) begin
        nrd++;
        rd_addr     = pit_address;
        pit_data_in = (rd_idx < 2) ? rdv[rd_idx] : 8'hEE;
        rd_idx++;
      end
    end
    cs_prev = pit_cs_n;
    wr_prev = pit_wr_n;
    rd_prev = pit_rd_n;
    a_prev  = pit_address;
    d_prev  = pit_data_out;
  end

  typedef struct {
    logic [1:0]  op, ctr, rw;
    logic [2:0]  mode;
    logic        bcd;
    logic [15:0] count;
    logic [7:0]  rd0, rd1;
    logic        err;
    logic [15:0] data;
    int          nwr, nrdx;
    logic [9:0]  w0, w1, w2;
    int          lat;
  } vec_t;

  vec_t vt [9];

`ifdef KF8253_SEQ_FIFO_EN
  localparam int LAT_OFS = 1;
`else
  localparam int LAT_OFS = 0;
`endif

  task automatic clear_logs(input logic [7:0] r0, input logic [7:0] r1);
    wlog.delete();
    rdv[0] = r0;
    rdv[1] = r1;
    rd_idx = 0;
    nrd    = 0;
    cs_low = 0;
  endtask

  task automatic drive_req(input vec_t v);
    req_op      = v.op;
    req_counter = v.ctr;
    req_rw      = v.rw;
    req_mode    = v.mode;
    req_bcd     = v.bcd;
    req_count   = v.count;
  endtask

  // Called at a negedge; returns cycles from the accepting edge to first rsp_valid (1 = next cycle).
  task automatic send(input vec_t v, output int lat);
    int g;
    drive_req(v);
    req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 200) begin
      @(negedge clock);
      g++;
    end
    @(negedge clock);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int   lat, g;
    logic bad, stall;
    vec_t v;

    vt[0] = '{2'b00, 2'd0, 2'b11, 3'd3, 1'b0, 16'h1234, 8'h00, 8'h00, 1'b0, 16'h0000, 3, 0,
              {2'd3, 8'h36}, {2'd0, 8'h34}, {2'd0, 8'h12}, 18};
    vt[1] = '{2'b01, 2'd2, 2'b11, 3'd0, 1'b0, 16'h0000, 8'hCD, 8'hAB, 1'b0, 16'hABCD, 1, 2,
              {2'd3, 8'h80}, 10'h0, 10'h0, 14};
    vt[2] = '{2'b00, 2'd1, 2'b01, 3'd2, 1'b1, 16'h00A5, 8'h00, 8'h00, 1'b0, 16'h0000, 2, 0,
              {2'd3, 8'h55}, {2'd1, 8'hA5}, 10'h0, 12};
    vt[3] = '{2'b00, 2'd2, 2'b10, 3'd0, 1'b0, 16'h7F00, 8'h00, 8'h00, 1'b0, 16'h0000, 2, 0,
              {2'd3, 8'hA0}, {2'd2, 8'h7F}, 10'h0, 12};
    vt[4] = '{2'b01, 2'd1, 2'b01, 3'd0, 1'b0, 16'h0000, 8'h5A, 8'h00, 1'b0, 16'h005A, 1, 1,
              {2'd3, 8'h40}, 10'h0, 10'h0, 10};
    vt[5] = '{2'b01, 2'd0, 2'b10, 3'd0, 1'b0, 16'h0000, 8'hC3, 8'h00, 1'b0, 16'hC300, 1, 1,
              {2'd3, 8'h00}, 10'h0, 10'h0, 10};
    vt[6] = '{2'b00, 2'd3, 2'b11, 3'd0, 1'b0, 16'h1111, 8'h00, 8'h00, 1'b1, 16'h0000, 0, 0,
              10'h0, 10'h0, 10'h0, 1};
    vt[7] = '{2'b00, 2'd0, 2'b00, 3'd0, 1'b0, 16'h2222, 8'h00, 8'h00, 1'b1, 16'h0000, 0, 0,
              10'h0, 10'h0, 10'h0, 1};
    vt[8] = '{2'b10, 2'd0, 2'b11, 3'd0, 1'b0, 16'h3333, 8'h00, 8'h00, 1'b1, 16'h0000, 0, 0,
              10'h0, 10'h0, 10'h0, 1};

    reset       = 1'b1;
    req_valid   = 1'b0;
    rsp_ready   = 1'b0;
    pit_data_in = 8'h00;
    drive_req(vt[0]);
    strobe_viol = 0;
    hold_viol   = 0;
    clear_logs(8'h00, 8'h00);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset cs_n", pit_cs_n, 1);
    check("reset wr_n", pit_wr_n, 1);
    check("reset rd_n", pit_rd_n, 1);
    check("reset addr", pit_address, 0);
    check("reset dout", pit_data_out, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_data", rsp_data, 0);
    check("reset rsp_error", rsp_error, 0);
    check("reset busy", busy, 0);
    check("reset req_ready", req_ready, 1);

    for (int i = 0; i < 9; i++) begin
      clear_logs(vt[i].rd0, vt[i].rd1);
      send(vt[i], lat);
      check($sformatf("v%0d latency", i), lat, vt[i].lat + LAT_OFS);
      check($sformatf("v%0d rsp_error", i), rsp_error, vt[i].err);
      check($sformatf("v%0d rsp_data", i), rsp_data, vt[i].data);
      check($sformatf("v%0d writes", i), wlog.size(), vt[i].nwr);
      check($sformatf("v%0d reads", i), nrd, vt[i].nrdx);
      check($sformatf("v%0d cs_low cycles", i), cs_low, 5 * vt[i].nwr + 3 * vt[i].nrdx);
      if (vt[i].nwr > 0 && wlog.size() > 0) check($sformatf("v%0d write0", i), wlog[0], vt[i].w0);
      if (vt[i].nwr > 1 && wlog.size() > 1) check($sformatf("v%0d write1", i), wlog[1], vt[i].w1);
      if (vt[i].nwr > 2 && wlog.size() > 2) check($sformatf("v%0d write2", i), wlog[2], vt[i].w2);
      if (vt[i].nrdx > 0) check($sformatf("v%0d read addr", i), rd_addr, vt[i].ctr);
      release_rsp();
      check($sformatf("v%0d rsp_valid cleared", i), rsp_valid, 0);
    end

    // Reset in the middle of the control-word strobe.
    clear_logs(8'h00, 8'h00);
    drive_req(vt[0]);
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    g = 0;
    while (pit_wr_n && g < 50) begin
      @(negedge clock);
      g++;
    end
    check("mid strobe wr_n low", pit_wr_n, 0);
    check("mid strobe busy", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    check("reset mid wr_n", pit_wr_n, 1);
    check("reset mid cs_n", pit_cs_n, 1);
    check("reset mid rsp_valid", rsp_valid, 0);
    check("reset mid busy", busy, 0);
`ifndef KF8253_SEQ_FIFO_EN
    check("reset mid req_ready", req_ready, 0);
`endif
    reset = 1'b0;
    #1;
    check("after reset req_ready", req_ready, 1);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (rsp_valid || !pit_cs_n) bad = 1'b1;
    end
    check("no activity after reset", bad, 0);

    // Response backpressure: response must hold steady and block new commands.
    v = vt[1];
    clear_logs(8'h11, 8'h22);
    send(v, lat);
    check("bp first rsp_valid", rsp_valid, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check($sformatf("bp%0d rsp_valid", k), rsp_valid, 1);
      check($sformatf("bp%0d rsp_data", k), rsp_data, 16'h2211);
`ifndef KF8253_SEQ_FIFO_EN
      check($sformatf("bp%0d req_ready", k), req_ready, 0);
`endif
    end
    release_rsp();

`ifdef KF8253_SEQ_FIFO_EN
    clear_logs(8'h00, 8'h00);
    rsp_ready = 1'b1;
    stall     = 1'b0;
    v = vt[2];
    v.ctr = 2'd0;
    v.mode = 3'd0;
    v.bcd = 1'b0;
    for (int k = 0; k < 6; k++) begin
      v.count = 16'(k + 1);
      drive_req(v);
      req_valid = 1'b1;
      g = 0;
      while (!req_ready && g < 500) begin
        stall = 1'b1;
        @(negedge clock);
        g++;
      end
      @(negedge clock);
    end
    req_valid = 1'b0;
    g = 0;
    while ((wlog.size() < 12 || busy || rsp_valid) && g < 1000) begin
      @(negedge clock);
      g++;
    end
    rsp_ready = 1'b0;
    check("fifo stall seen", stall, 1);
    check("fifo write count", wlog.size(), 12);
    for (int k = 0; k < 6; k++) begin
      if (wlog.size() > 2 * k + 1)
        check($sformatf("fifo order %0d", k), wlog[2*k+1], {2'd0, 8'(k + 1)});
    end
`endif

    check("strobe overlap count", strobe_viol, 0);
    check("addr/data change under cs", hold_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
